// File: rtl/apb_master.sv
// APB requester: runs one valid/ready command at a time as an APB SETUP/ACCESS
// transfer. It returns read data or a timeout error on a valid/ready response port.
module apb_master #(
  parameter int unsigned ADDR_W  = 4,
  parameter int unsigned DATA_W  = 8,
  parameter int unsigned TIMEOUT = 16
) (
  input  logic              PCLK,
  input  logic              PRESET,
  input  logic              cmd_valid,
  output logic              cmd_ready,
  input  logic              cmd_write,
  input  logic [ADDR_W-1:0] cmd_addr,
  input  logic [DATA_W-1:0] cmd_wdata,
  output logic              rsp_valid,
  input  logic              rsp_ready,
  output logic [DATA_W-1:0] rsp_rdata,
  output logic              rsp_err,
  output logic              PSELx,
  output logic              PENABLE,
  output logic              PWRITE,
  output logic [ADDR_W-1:0] PADDR,
  output logic [DATA_W-1:0] PWDATA,
  input  logic [DATA_W-1:0] PRDATA,
  input  logic              PREADY
);

  localparam int unsigned CW = $clog2(TIMEOUT + 1);
  localparam logic [CW-1:0] WAIT_LAST = CW'(TIMEOUT - 1);

  typedef enum logic [1:0] {
    S_IDLE,
    S_SETUP,
    S_ACCESS,
    S_RESP
  } state_t;

  state_t            r_state;
  state_t            w_state_nxt;
  logic [CW-1:0]     r_wait;
  logic [CW-1:0]     w_wait_nxt;
  logic              r_psel,      w_psel_nxt;
  logic              r_penable,   w_penable_nxt;
  logic              r_pwrite,    w_pwrite_nxt;
  logic [ADDR_W-1:0] r_paddr,     w_paddr_nxt;
  logic [DATA_W-1:0] r_pwdata,    w_pwdata_nxt;
  logic              r_rsp_valid, w_rsp_valid_nxt;
  logic [DATA_W-1:0] r_rsp_rdata, w_rsp_rdata_nxt;
  logic              r_rsp_err,   w_rsp_err_nxt;

  always_ff @(posedge PCLK or posedge PRESET) begin
    if (PRESET) begin
      r_state     <= S_IDLE;
      r_wait      <= '0;
      r_psel      <= 1'b0;
      r_penable   <= 1'b0;
      r_pwrite    <= 1'b0;
      r_paddr     <= '0;
      r_pwdata    <= '0;
      r_rsp_valid <= 1'b0;
      r_rsp_rdata <= '0;
      r_rsp_err   <= 1'b0;
    end else begin
      r_state     <= w_state_nxt;
      r_wait      <= w_wait_nxt;
      r_psel      <= w_psel_nxt;
      r_penable   <= w_penable_nxt;
      r_pwrite    <= w_pwrite_nxt;
      r_paddr     <= w_paddr_nxt;
      r_pwdata    <= w_pwdata_nxt;
      r_rsp_valid <= w_rsp_valid_nxt;
      r_rsp_rdata <= w_rsp_rdata_nxt;
      r_rsp_err   <= w_rsp_err_nxt;
    end
  end

  // Next-state logic also computes the next value of every registered output,
  // so the APB and response ports come straight from flops.
  always_comb begin
    w_state_nxt     = r_state;
    w_wait_nxt      = r_wait;
    w_psel_nxt      = r_psel;
    w_penable_nxt   = r_penable;
    w_pwrite_nxt    = r_pwrite;
    w_paddr_nxt     = r_paddr;
    w_pwdata_nxt    = r_pwdata;
    w_rsp_valid_nxt = r_rsp_valid;
    w_rsp_rdata_nxt = r_rsp_rdata;
    w_rsp_err_nxt   = r_rsp_err;

    case (r_state)
      S_IDLE: begin
        if (cmd_valid) begin
          w_pwrite_nxt = cmd_write;
          w_paddr_nxt  = cmd_addr;
          w_pwdata_nxt = cmd_wdata;
          w_psel_nxt   = 1'b1;
          w_state_nxt  = S_SETUP;
        end
      end
      S_SETUP: begin
        w_penable_nxt = 1'b1;
        w_wait_nxt    = '0;
        w_state_nxt   = S_ACCESS;
      end
      S_ACCESS: begin
        if (PREADY) begin
          w_rsp_rdata_nxt = r_pwrite ? '0 : PRDATA;
          w_rsp_err_nxt   = 1'b0;
          w_rsp_valid_nxt = 1'b1;
          w_psel_nxt      = 1'b0;
          w_penable_nxt   = 1'b0;
          w_state_nxt     = S_RESP;
        end else if (r_wait == WAIT_LAST) begin
          w_rsp_rdata_nxt = '0;
          w_rsp_err_nxt   = 1'b1;
          w_rsp_valid_nxt = 1'b1;
          w_psel_nxt      = 1'b0;
          w_penable_nxt   = 1'b0;
          w_state_nxt     = S_RESP;
        end else begin
          w_wait_nxt = r_wait + 1'b1;
        end
      end
      S_RESP: begin
        if (rsp_ready) begin
          w_rsp_valid_nxt = 1'b0;
          w_state_nxt     = S_IDLE;
        end
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  assign cmd_ready = (r_state == S_IDLE);
  assign rsp_valid = r_rsp_valid;
  assign rsp_rdata = r_rsp_rdata;
  assign rsp_err   = r_rsp_err;
  assign PSELx     = r_psel;
  assign PENABLE   = r_penable;
  assign PWRITE    = r_pwrite;
  assign PADDR     = r_paddr;
  assign PWDATA    = r_pwdata;

endmodule

// File: tb/tb_apb_master.sv
// Bench for apb_master: directed commands against a small memory slave with
// programmable wait states, checked every cycle against a transaction-level model.
module tb_apb_master;
  localparam int unsigned AW = 4;
  localparam int unsigned DW = 8;
  localparam int unsigned TO = 16;

  logic          PCLK = 1'b0;
  logic          PRESET = 1'b1;
  logic          cmd_valid, cmd_ready, cmd_write;
  logic [AW-1:0] cmd_addr;
  logic [DW-1:0] cmd_wdata;
  logic          rsp_valid, rsp_ready, rsp_err;
  logic [DW-1:0] rsp_rdata;
  logic          PSELx, PENABLE, PWRITE, PREADY;
  logic [AW-1:0] PADDR;
  logic [DW-1:0] PWDATA, PRDATA;

  apb_master #(.ADDR_W(AW), .DATA_W(DW), .TIMEOUT(TO)) dut (
    .PCLK(PCLK), .PRESET(PRESET),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_write(cmd_write),
    .cmd_addr(cmd_addr), .cmd_wdata(cmd_wdata),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_rdata(rsp_rdata), .rsp_err(rsp_err),
    .PSELx(PSELx), .PENABLE(PENABLE), .PWRITE(PWRITE), .PADDR(PADDR),
    .PWDATA(PWDATA), .PRDATA(PRDATA), .PREADY(PREADY)
  );

  always #5 PCLK = ~PCLK;

  int total = 0;
  int bad   = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Slave: memory plus a wait-state count of PREADY-low ACCESS cycles.
  logic [DW-1:0] mem [16];
  int unsigned   slv_wait_cfg;
  int unsigned   slv_cnt;

  assign PREADY = (slv_cnt >= slv_wait_cfg);
  assign PRDATA = mem[PADDR];

  always @(posedge PCLK or posedge PRESET) begin
    if (PRESET) slv_cnt <= 0;
    else if (PSELx && PENABLE && !PREADY) slv_cnt <= slv_cnt + 1;
    else slv_cnt <= 0;
  end

  always @(posedge PCLK) begin
    if (PSELx && PENABLE && PREADY && PWRITE) mem[PADDR] <= PWDATA;
  end

  // Transaction model: edges since accept and PREADY-low cycles seen.
  logic          m_infl, m_resp, m_wr, m_err;
  int            m_age, m_waits;
  logic [AW-1:0] m_addr;
  logic [DW-1:0] m_wdata, m_rdata;

  always @(posedge PCLK or posedge PRESET) begin
    if (PRESET) begin
      m_infl <= 1'b0; m_resp <= 1'b0; m_wr <= 1'b0; m_err <= 1'b0;
      m_age <= 0; m_waits <= 0; m_addr <= '0; m_wdata <= '0; m_rdata <= '0;
    end else if (m_resp) begin
      if (rsp_ready) m_resp <= 1'b0;
    end else if (m_infl) begin
      if (m_age == 0) m_age <= 1;
      else if (PREADY) begin
        m_rdata <= m_wr ? '0 : PRDATA;
        m_err <= 1'b0; m_resp <= 1'b1; m_infl <= 1'b0;
      end else if (m_waits + 1 == int'(TO)) begin
        m_rdata <= '0; m_err <= 1'b1; m_resp <= 1'b1; m_infl <= 1'b0;
      end else m_waits <= m_waits + 1;
    end else if (cmd_valid) begin
      m_wr <= cmd_write; m_addr <= cmd_addr; m_wdata <= cmd_wdata;
      m_infl <= 1'b1; m_age <= 0; m_waits <= 0;
    end
  end

  logic chk_en = 1'b0;

  always @(negedge PCLK) begin
    if (chk_en) begin
      check("cmd_ready", 32'(cmd_ready), 32'(!m_infl && !m_resp));
      check("PSELx",     32'(PSELx),     32'(m_infl));
      check("PENABLE",   32'(PENABLE),   32'(m_infl && m_age >= 1));
      check("PWRITE",    32'(PWRITE),    32'(m_wr));
      check("PADDR",     32'(PADDR),     32'(m_addr));
      check("PWDATA",    32'(PWDATA),    32'(m_wdata));
      check("rsp_valid", 32'(rsp_valid), 32'(m_resp));
      check("rsp_rdata", 32'(rsp_rdata), 32'(m_rdata));
      check("rsp_err",   32'(rsp_err),   32'(m_err));
    end
  end

  int setup_cnt = 0;
  int acc_cnt   = 0;
  always @(negedge PCLK) begin
    if (PSELx && !PENABLE) setup_cnt <= setup_cnt + 1;
    if (PSELx && PENABLE)  acc_cnt   <= acc_cnt + 1;
  end

  task automatic send(input logic wr, input logic [AW-1:0] a, input logic [DW-1:0] d);
    int n = 0;
    cmd_valid = 1'b1; cmd_write = wr; cmd_addr = a; cmd_wdata = d;
    while (!cmd_ready && n < 60) begin @(negedge PCLK); n++; end
    check("accept_seen", 32'(cmd_ready), 32'h1);
    @(posedge PCLK);
    @(negedge PCLK);
    cmd_valid = 1'b0; cmd_write = ~wr; cmd_addr = ~a; cmd_wdata = ~d;
  endtask

  task automatic wait_rsp();
    int n = 0;
    while (!rsp_valid && n < 60) begin @(negedge PCLK); n++; end
    check("rsp_seen", 32'(rsp_valid), 32'h1);
  endtask

  task automatic finish_rsp();
    rsp_ready = 1'b1;
    @(negedge PCLK);
    rsp_ready = 1'b0;
  endtask

  int s0, a0;

  initial begin
    cmd_valid = 1'b0; cmd_write = 1'b0; cmd_addr = '0; cmd_wdata = '0;
    rsp_ready = 1'b0; slv_wait_cfg = 0;
    repeat (2) @(negedge PCLK);
    check("rst_cmd_ready", 32'(cmd_ready), 32'h1);
    check("rst_psel",      32'(PSELx),     32'h0);
    check("rst_rsp_valid", 32'(rsp_valid), 32'h0);
    check("rst_paddr",     32'(PADDR),     32'h0);
    PRESET = 1'b0;
    chk_en = 1'b1;
    @(negedge PCLK);

    // Zero-wait write
    s0 = setup_cnt; a0 = acc_cnt;
    send(1'b1, 4'd3, 8'hA5);
    wait_rsp();
    check("wr_paddr",  32'(PADDR),     32'h3);
    check("wr_pwdata", 32'(PWDATA),    32'hA5);
    check("wr_pwrite", 32'(PWRITE),    32'h1);
    check("wr_rdata",  32'(rsp_rdata), 32'h0);
    check("wr_err",    32'(rsp_err),   32'h0);
    check("wr_setup_cycles",  32'(setup_cnt - s0), 32'd1);
    check("wr_access_cycles", 32'(acc_cnt - a0),   32'd1);
    finish_rsp();

    // Read with three wait states
    slv_wait_cfg = 3;
    s0 = setup_cnt; a0 = acc_cnt;
    send(1'b0, 4'd3, 8'h00);
    wait_rsp();
    check("rd_access_cycles", 32'(acc_cnt - a0), 32'd4);
    check("rd_rdata", 32'(rsp_rdata), 32'hA5);
    check("rd_err",   32'(rsp_err),   32'h0);
    finish_rsp();

    // Timeout
    slv_wait_cfg = 255;
    a0 = acc_cnt;
    send(1'b0, 4'd5, 8'h00);
    wait_rsp();
    check("to_access_cycles", 32'(acc_cnt - a0), 32'd16);
    check("to_err",   32'(rsp_err),   32'h1);
    check("to_rdata", 32'(rsp_rdata), 32'h0);
    check("to_psel",  32'(PSELx),     32'h0);
    check("to_pen",   32'(PENABLE),   32'h0);
    finish_rsp();

    // Response backpressure with a competing command
    slv_wait_cfg = 0;
    send(1'b1, 4'd7, 8'h5A);
    wait_rsp();
    cmd_valid = 1'b1; cmd_write = 1'b0; cmd_addr = 4'd3; cmd_wdata = 8'h11;
    for (int i = 0; i < 5; i++) begin
      @(negedge PCLK);
      check("bp_cmd_ready", 32'(cmd_ready), 32'h0);
      check("bp_rsp_valid", 32'(rsp_valid), 32'h1);
      check("bp_paddr",     32'(PADDR),     32'h7);
    end
    rsp_ready = 1'b1;
    send(1'b0, 4'd3, 8'h00);
    wait_rsp();
    check("bp_rd_rdata", 32'(rsp_rdata), 32'hA5);
    @(negedge PCLK);

    // Back-to-back with rsp_ready high
    send(1'b1, 4'd1, 8'h3C);
    send(1'b0, 4'd1, 8'h00);
    wait_rsp();
    check("b2b_rdata", 32'(rsp_rdata), 32'h3C);
    @(negedge PCLK);

    // Asynchronous reset in ACCESS
    slv_wait_cfg = 255;
    send(1'b0, 4'd2, 8'h00);
    repeat (2) @(negedge PCLK);
    check("pre_rst_pen", 32'(PENABLE), 32'h1);
    #2 PRESET = 1'b1;
    #1;
    check("arst_psel",      32'(PSELx),     32'h0);
    check("arst_pen",       32'(PENABLE),   32'h0);
    check("arst_rsp_valid", 32'(rsp_valid), 32'h0);
    check("arst_cmd_ready", 32'(cmd_ready), 32'h1);
    check("arst_paddr",     32'(PADDR),     32'h0);
    @(negedge PCLK);
    PRESET = 1'b0;
    slv_wait_cfg = 0;
    send(1'b1, 4'd2, 8'h77);
    wait_rsp();
    check("post_rst_err", 32'(rsp_err), 32'h0);
    @(negedge PCLK);
    send(1'b0, 4'd2, 8'h00);
    wait_rsp();
    check("post_rst_rdata", 32'(rsp_rdata), 32'h77);
    repeat (3) @(negedge PCLK);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
